reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 126 ++++++++++++
 tb/tb_reg_file_mp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port GPR file with WB/link write ports, read bypass and clear sweep
module reg_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          link_we,
  input  logic [DW-3:0] link_pc,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          wr_dropped
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LINK_A  = AW'(LINK_REG);
  localparam logic [AW-1:0] LAST_A  = AW'(NREG - 1);
  localparam bit            LINK_OK = (LINK_REG != 0) && (LINK_REG < NREG);
  localparam bit            BYP     = (BYPASS != 0);

  logic [DW-1:0] rf [NREG];
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          drop_q, drop_d;
  logic          wa_ok, ra1_ok, ra2_ok;
  logic [DW-3:0] link_inc;
  logic [DW-1:0] link_data;
  logic          byp_en;

  // Addresses at or above NREG are unimplemented; register 0 is hardwired to zero.
  if (NREG >= (1 << AW)) begin : g_full
    assign wa_ok  = (wa  != '0);
    assign ra1_ok = (ra1 != '0);
    assign ra2_ok = (ra2 != '0);
  end else begin : g_part
    localparam logic [AW-1:0] NREG_A = AW'(NREG);
    assign wa_ok  = (wa  != '0) && (wa  < NREG_A);
    assign ra1_ok = (ra1 != '0) && (ra1 < NREG_A);
    assign ra2_ok = (ra2 != '0) && (ra2 < NREG_A);
  end

  assign link_inc  = link_pc + (DW-2)'(1);
  assign link_data = {link_inc, 2'b00};
  assign byp_en    = BYP && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    drop_d   = drop_q;
    clr_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = AW'(1);
          drop_d  = 1'b0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if ((we && wa_ok) || (link_we && LINK_OK)) drop_d = 1'b1;
        if (ptr_q == LAST_A) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Link port is written last so it overrides a WB write to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state_q == CLEAR) begin
      rf[ptr_q] <= '0;
    end else begin
      if (we && wa_ok)        rf[wa]     <= wd;
      if (link_we && LINK_OK) rf[LINK_A] <= link_data;
    end
  end

  always_comb begin
    rd1 = ra1_ok ? rf[ra1] : '0;
    if (byp_en) begin
      if (link_we && LINK_OK && ra1 == LINK_A) rd1 = link_data;
      else if (we && wa_ok && ra1 == wa)       rd1 = wd;
    end
  end

  always_comb begin
    rd2 = ra2_ok ? rf[ra2] : '0;
    if (byp_en) begin
      if (link_we && LINK_OK && ra2 == LINK_A) rd2 = link_data;
      else if (we && wa_ok && ra2 == wa)       rd2 = wd;
    end
  end

  assign wr_dropped = drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed scoreboard bench for reg_file_mp
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we, link_we, clr_req;
  logic [29:0] link_pc;
  logic        clr_busy, wr_dropped;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  n;

  reg_file_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .link_we    (link_we),
    .link_pc    (link_pc),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .wr_dropped (wr_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle_in();
    we = 0; wa = 0; wd = 0; link_we = 0; link_pc = 0; clr_req = 0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_in();
    we = 1; wa = a; wd = d;
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    rst_n = 0; ra1 = 5; ra2 = 0;
    idle_in();
    #1;
    push("rst_rd1", 32'h0);       pop_check(rd1);
    push("rst_busy", 32'h0);      pop_check({31'h0, clr_busy});
    push("rst_dropped", 32'h0);   pop_check({31'h0, wr_dropped});
    @(negedge clk);
    rst_n = 1;

    // bypass of WB write, then stored value
    @(negedge clk);
    we = 1; wa = 5; wd = 32'hDEADBEEF; ra1 = 5; ra2 = 6;
    #1;
    push("wb_bypass", 32'hDEADBEEF); pop_check(rd1);
    push("other_rd2", 32'h0);        pop_check(rd2);
    @(negedge clk);
    idle_in();
    #1;
    push("wb_stored", 32'hDEADBEEF); pop_check(rd1);

    // writes to r0 are dropped silently
    @(negedge clk);
    we = 1; wa = 0; wd = 32'h1234; ra1 = 0;
    #1;
    push("r0_bypass", 32'h0);     pop_check(rd1);
    @(negedge clk);
    idle_in();
    #1;
    push("r0_stored", 32'h0);     pop_check(rd1);
    push("r0_dropped", 32'h0);    pop_check({31'h0, wr_dropped});

    // link port beats WB on r31
    @(negedge clk);
    link_we = 1; link_pc = 30'h0000_1000; we = 1; wa = 31; wd = 32'h5; ra1 = 31;
    #1;
    push("link_bypass", 32'h0000_4004); pop_check(rd1);
    @(negedge clk);
    idle_in();
    #1;
    push("link_stored", 32'h0000_4004); pop_check(rd1);

    // link PC wrap
    @(negedge clk);
    link_we = 1; link_pc = 30'h3FFF_FFFF; ra2 = 31;
    #1;
    push("wrap_bypass", 32'h0);   pop_check(rd2);
    @(negedge clk);
    idle_in();
    #1;
    push("wrap_stored", 32'h0);   pop_check(rd2);

    // fill r1..r31 then sweep
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    ra1 = 7; ra2 = 31;
    #1;
    push("fill_r7", 32'd7);       pop_check(rd1);
    push("fill_r31", 32'd31);     pop_check(rd2);
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      idle_in();
      if (n == 5) begin
        we = 1; wa = 3; wd = 32'hABC; ra1 = 3; ra2 = 20;
        #1;
        push("sweep_no_bypass", 32'h0); pop_check(rd1);
        push("sweep_unswept", 32'd20);  pop_check(rd2);
      end
      if (n == 8) clr_req = 1;
      @(negedge clk);
    end
    idle_in();
    push("busy_cycles", 32'd31);  pop_check(32'(n));
    push("sweep_dropped", 32'h1); pop_check({31'h0, wr_dropped});
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      push($sformatf("cleared_r%0d", i), 32'h0); pop_check(rd1);
    end
    @(negedge clk);
    @(negedge clk);
    push("no_requeue", 32'h0);    pop_check({31'h0, clr_busy});

    // async reset mid-sweep
    write_reg(5'd20, 32'h2020);
    write_reg(5'd31, 32'h3131);
    @(negedge clk);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    #1;
    push("entry_busy", 32'h1);    pop_check({31'h0, clr_busy});
    push("entry_drop_clr", 32'h0); pop_check({31'h0, wr_dropped});
    ra1 = 20; ra2 = 31;
    for (int i = 1; i < 10; i++) @(negedge clk);
    #1;
    push("pre_rst_r20", 32'h2020); pop_check(rd1);
    #1;
    rst_n = 0;
    #1;
    push("arst_busy", 32'h0);     pop_check({31'h0, clr_busy});
    push("arst_r20", 32'h0);      pop_check(rd1);
    push("arst_r31", 32'h0);      pop_check(rd2);
    @(negedge clk);
    rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
